mem_dump_reader: RTL and testbench

//  External read-out engine for the data DRAM. Takes the memory read port
//  (memread_en/out_addr) that sits beside the MEM stage, walks a block of

---
 rtl/mem_dump_reader.sv | 125 ++++++++++++
 tb/tb_mem_dump_reader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_reader.sv
// rtl/mem_dump_reader.sv - DRAM block read-out engine streaming words as little-endian bytes
module mem_dump_reader #(
  parameter int ADDR_W     = 10,
  parameter int START_ADDR = 0,
  parameter int WORD_COUNT = 256,
  parameter int READ_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              memread_en,
  output logic [ADDR_W-1:0] out_addr,
  input  logic [31:0]       mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RD, TX, DONE} state_t;

  // Latency counter only needs to reach READ_LAT-1; keep at least one bit.
  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  // A full ADDR_W-wide word counter comfortably holds WORD_COUNT-1.
  localparam int CNT_W = ADDR_W;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  word_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic [1:0]        byte_idx;
  logic [31:0]       word;

  logic accept;
  logic last_lat;
  logic last_byte;
  logic last_word;

  // Handshake and terminal-count decodes.
  assign accept    = tx_valid && tx_ready;
  assign last_lat  = (lat_cnt == LAT_W'(READ_LAT - 1));
  assign last_byte = (byte_idx == 2'd3);
  assign last_word = (word_cnt == CNT_W'(WORD_COUNT - 1));

  // Outputs decoded from state only, so async reset clears them immediately.
  assign memread_en = (state == RD);
  assign tx_valid   = (state == TX);
  assign busy       = (state == RD) || (state == TX);
  assign done       = (state == DONE);
  assign out_addr   = addr;
  assign tx_data    = word[{byte_idx, 3'b000} +: 8];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides every other event.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (start) state_nxt = RD;
        RD:   if (last_lat) state_nxt = TX;
        TX:   if (accept && last_byte) state_nxt = last_word ? DONE : RD;
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Address, counters and captured word; addr wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= ADDR_W'(START_ADDR);
      word_cnt <= '0;
      lat_cnt  <= '0;
      byte_idx <= '0;
      word     <= '0;
    end else if (abort) begin
      lat_cnt  <= '0;
      byte_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr     <= ADDR_W'(START_ADDR);
            word_cnt <= '0;
            lat_cnt  <= '0;
          end
        end
        RD: begin
          if (last_lat) begin
            word     <= mem_rdata;
            byte_idx <= '0;
            lat_cnt  <= '0;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        TX: begin
          if (accept) begin
            if (!last_byte) begin
              byte_idx <= byte_idx + 2'd1;
            end else if (!last_word) begin
              byte_idx <= '0;
              addr     <= addr + ADDR_W'(4);
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// tb/tb_mem_dump_reader.sv - randomized self-checking bench for mem_dump_reader
module tb_mem_dump_reader;

  localparam int AW = 10;
  localparam int SA = 'h3F8;
  localparam int WC = 6;
  localparam int RL = 3;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          memread_en;
  logic [AW-1:0] out_addr;
  logic [31:0]   mem_rdata;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          done;

  mem_dump_reader #(
    .ADDR_W(AW), .START_ADDR(SA), .WORD_COUNT(WC), .READ_LAT(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .memread_en(memread_en), .out_addr(out_addr), .mem_rdata(mem_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  logic [7:0]  exp_bytes [$];
  logic [7:0]  got_bytes [$];
  int          got_addr  [$];
  int          rd_pos;
  int          run;
  int          busy_cnt;
  int          done_cnt;
  bit          mon_en;
  bit          have_prev;
  logic        prev_v, prev_r, prev_ab;
  logic [7:0]  prev_d;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got_v, exp_v);
    end
  endtask

  // Memory only returns correct data in the last of the READ_LAT read cycles.
  always @(posedge clk) rd_pos <= memread_en ? rd_pos + 1 : 0;
  assign mem_rdata = (memread_en && rd_pos == RL - 1) ? mem[out_addr[9:2]] : ~mem[out_addr[9:2]];

  // Stream monitor: collects accepted bytes, read addresses, and checks hold rules.
  always @(negedge clk) begin
    if (!mon_en) begin
      run       = 0;
      have_prev = 1'b0;
    end else begin
      if (have_prev && prev_v && !prev_r && !prev_ab) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, prev_d);
      end
      if (tx_valid && tx_ready) got_bytes.push_back(tx_data);
      if (memread_en) begin
        if (run == 0) got_addr.push_back(int'(out_addr));
        run++;
      end else if (run != 0) begin
        check("rd_len", run, RL);
        run = 0;
      end
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      prev_v    = tx_valid;
      prev_r    = tx_ready;
      prev_ab   = abort;
      prev_d    = tx_data;
      have_prev = 1'b1;
    end
  end

  // mode 0: ready always high; 1: random ready, backpressure on byte 2, stray starts; 2: abort
  task automatic run_dump(input int mode);
    int  cyc;
    int  hold;
    int  nexp;
    bit  finished;
    logic [31:0] w;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    if (mode == 0) mem[SA >> 2] = 32'h11223344;
    exp_bytes.delete();
    for (int k = 0; k < WC; k++) begin
      w = mem[((SA + 4 * k) % 1024) / 4];
      for (int b = 0; b < 4; b++) exp_bytes.push_back(8'((w >> (8 * b)) & 32'hFF));
    end
    got_bytes.delete();
    got_addr.delete();
    busy_cnt = 0;
    done_cnt = 0;
    mon_en   = 1'b1;
    hold     = 0;
    finished = 1'b0;
    cyc      = 0;
    start    = 1'b1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    while (!finished && cyc < 2000) begin
      start = 1'b0;
      abort = 1'b0;
      case (mode)
        1: begin
          if (got_bytes.size() == 2 && hold < 5) begin
            tx_ready = 1'b0;
            if (hold == 0) check("bp_byte", tx_data, exp_bytes[2]);
            hold++;
          end else begin
            tx_ready = ($urandom_range(0, 3) != 0);
          end
          start = busy && ($urandom_range(0, 7) == 0);
        end
        2: begin
          tx_ready = 1'b1;
          if (got_bytes.size() == 21) abort = 1'b1;
        end
        default: tx_ready = 1'b1;
      endcase
      if (done) begin
        start    = (mode == 1);
        finished = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (abort) finished = 1'b1;
    end
    check("timeout", finished, 1);
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("idle_busy", busy, 0);
      check("idle_rd", memread_en, 0);
      check("idle_valid", tx_valid, 0);
      @(posedge clk); #1;
    end
    mon_en = 1'b0;
    @(posedge clk); #1;
    nexp = (mode == 2) ? 22 : WC * 4;
    check("nbytes", got_bytes.size(), nexp);
    for (int i = 0; i < nexp && i < got_bytes.size(); i++)
      check($sformatf("byte%0d", i), got_bytes[i], exp_bytes[i]);
    check("done_cnt", done_cnt, (mode == 2) ? 0 : 1);
    if (mode == 0) check("busy_cycles", busy_cnt, WC * (RL + 4));
    check("nwords", got_addr.size(), WC);
    for (int i = 0; i < got_addr.size(); i++)
      check($sformatf("addr%0d", i), got_addr[i], (SA + 4 * i) % 1024);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    tx_ready = 1'b0;
    mon_en   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", out_addr, SA);
    check("rst_rd", memread_en, 0);
    check("rst_valid", tx_valid, 0);
    check("rst_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_dump(0);
    run_dump(1);
    run_dump(2);
    run_dump(0);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_rd", memread_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rd", memread_en, 0);
    check("async_valid", tx_valid, 0);
    check("async_busy", busy, 0);
    check("async_addr", out_addr, SA);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_addr", out_addr, SA);
    check("post_rst_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
